// File: rtl/puf_pkg.sv
// Shared types and constants for the multi-channel race arbiter.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RACE  = 2'd1,
        REARM = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Vote encoding: path A first counts as 0, path B first counts as 1.
    localparam logic VOTE_A = 1'b0;
    localparam logic VOTE_B = 1'b1;

endpackage

// File: rtl/race_channel.sv
// One race channel: decided flag, tie/timeout sticky bits, vote counter and
// majority compare. Sequenced by strobes from the top-level FSM.
module race_channel
    import puf_pkg::*;
#(
    parameter int REPEATS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sample,       // this edge samples the finish lines
    input  logic i_timeout_edge, // this edge is the last sample of the race
    input  logic i_clr_all,      // drop votes, sticky bits and decided flag
    input  logic i_clr_dec,      // drop only the decided flag (between repeats)
    input  logic i_fin_a,
    input  logic i_fin_b,
    output logic o_dec_nxt,      // decided after this edge's update
    output logic o_resp,
    output logic o_tie,
    output logic o_tmo
);

    localparam int VW = $clog2(REPEATS + 1);
    localparam logic [VW-1:0] HALF = VW'(REPEATS / 2);
    localparam logic [VW-1:0] MAXV = VW'(REPEATS);

    logic          r_dec;
    logic [VW-1:0] r_vote;
    logic          r_tie;
    logic          r_tmo;
    logic          r_resp;

    logic          w_live;
    logic          w_fin;
    logic          w_vote;
    logic          w_resolve;
    logic          w_inc;
    logic [VW-1:0] w_vote_nxt;

    // Only an undecided channel reacts; later input changes are ignored.
    assign w_live     = i_sample & ~r_dec;
    assign w_fin      = i_fin_a | i_fin_b;
    assign w_vote     = (i_fin_b & ~i_fin_a) ? VOTE_B : VOTE_A;
    assign w_resolve  = w_live & (w_fin | i_timeout_edge);
    // Saturation guard keeps the counter within REPEATS even on misuse.
    assign w_inc      = w_live & w_fin & (w_vote == VOTE_B) & (r_vote != MAXV);
    assign w_vote_nxt = w_inc ? r_vote + VW'(1) : r_vote;
    assign o_dec_nxt  = r_dec | w_resolve;

    // Channel state: resolve on sample, sticky flags, registered majority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec  <= 1'b0;
            r_vote <= '0;
            r_tie  <= 1'b0;
            r_tmo  <= 1'b0;
            r_resp <= 1'b0;
        end else if (i_clr_all) begin
            r_dec  <= 1'b0;
            r_vote <= '0;
            r_tie  <= 1'b0;
            r_tmo  <= 1'b0;
            r_resp <= 1'b0;
        end else begin
            if (i_clr_dec)
                r_dec <= 1'b0;
            else if (w_resolve)
                r_dec <= 1'b1;
            if (w_live & i_fin_a & i_fin_b)
                r_tie <= 1'b1;
            if (w_live & ~w_fin & i_timeout_edge)
                r_tmo <= 1'b1;
            r_vote <= w_vote_nxt;
            r_resp <= (w_vote_nxt > HALF);
        end
    end

    assign o_resp = r_resp;
    assign o_tie  = r_tie;
    assign o_tmo  = r_tmo;

endmodule

// File: rtl/race_arbiter_array.sv
// Multi-channel clocked race arbiter: launches N_CH races together, repeats
// them REPEATS times with a rearm gap, and hands the per-channel majority
// response to the consumer over valid/ready.
module race_arbiter_array
    import puf_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int TIMEOUT   = 16,
    parameter int REPEATS   = 1,
    parameter int REARM_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_CH-1:0] fin_a,
    input  logic [N_CH-1:0] fin_b,
    output logic            race_en,
    output logic            busy,
    output logic [N_CH-1:0] resp,
    output logic [N_CH-1:0] tie,
    output logic [N_CH-1:0] tmo,
    output logic            resp_valid,
    input  logic            resp_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int VW = $clog2(REPEATS + 1);
    localparam int RW = $clog2(REARM_CYC + 1);

    arb_state_e    r_state;
    logic          r_race_en;
    logic          r_busy;
    logic          r_resp_valid;
    logic          r_skip;     // RACE-entry cycle of a later repeat: no sample
    logic [CW-1:0] r_cyc;
    logic [VW-1:0] r_rep;
    logic [RW-1:0] r_rearm;

    logic            w_sample;
    logic            w_tmo_edge;
    logic            w_clr_all;
    logic            w_clr_dec;
    logic            w_all_dec;
    logic [N_CH-1:0] w_dec_nxt;

    assign w_sample   = (r_state == RACE) & ~r_skip;
    assign w_tmo_edge = w_sample & (r_cyc == CW'(TIMEOUT - 1));
    assign w_clr_all  = (r_state == IDLE);
    assign w_clr_dec  = (r_state == REARM);
    assign w_all_dec  = &w_dec_nxt;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        race_channel #(
            .REPEATS(REPEATS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_sample      (w_sample),
            .i_timeout_edge(w_tmo_edge),
            .i_clr_all     (w_clr_all),
            .i_clr_dec     (w_clr_dec),
            .i_fin_a       (fin_a[g]),
            .i_fin_b       (fin_b[g]),
            .o_dec_nxt     (w_dec_nxt[g]),
            .o_resp        (resp[g]),
            .o_tie         (tie[g]),
            .o_tmo         (tmo[g])
        );
    end

    // Sequencer FSM with registered race_en / busy / resp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_race_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_skip       <= 1'b0;
            r_cyc        <= '0;
            r_rep        <= '0;
            r_rearm      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cyc   <= '0;
                    r_rep   <= '0;
                    r_rearm <= '0;
                    r_skip  <= 1'b0;
                    if (start) begin
                        r_state   <= RACE;
                        r_race_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                RACE: begin
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (w_all_dec || w_tmo_edge) begin
                        r_race_en <= 1'b0;
                        r_rep     <= r_rep + VW'(1);
                        if (r_rep == VW'(REPEATS - 1)) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= REARM;
                            r_rearm <= '0;
                        end
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
                REARM: begin
                    r_cyc <= '0;
                    if (r_rearm == RW'(REARM_CYC - 1)) begin
                        r_state   <= RACE;
                        r_race_en <= 1'b1;
                        r_skip    <= 1'b1;
                    end else begin
                        r_rearm <= r_rearm + RW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_race_en    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign race_en    = r_race_en;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;

endmodule

// File: tb/tb_race_arbiter_array.sv
// Directed bench: a REPEATS=1 instance for single-race, tie/timeout and
// backpressure cases, and a REPEATS=3 instance for majority and reset cases.
module tb_race_arbiter_array;

    logic       clk;
    logic       rst1_n, start1, rdy1, en1, busy1, vld1;
    logic [3:0] fa1, fb1, resp1, tie1, tmo1;
    logic       rst3_n, start3, rdy3, en3, busy3, vld3;
    logic [3:0] fa3, fb3, resp3, tie3, tmo3;

    int errs   = 0;
    int checks = 0;

    race_arbiter_array #(.N_CH(4), .TIMEOUT(16), .REPEATS(1), .REARM_CYC(2)) u_r1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .fin_a(fa1), .fin_b(fb1),
        .race_en(en1), .busy(busy1), .resp(resp1), .tie(tie1), .tmo(tmo1),
        .resp_valid(vld1), .resp_ready(rdy1)
    );

    race_arbiter_array #(.N_CH(4), .TIMEOUT(16), .REPEATS(3), .REARM_CYC(2)) u_r3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .fin_a(fa3), .fin_b(fb3),
        .race_en(en3), .busy(busy3), .resp(resp3), .tie(tie3), .tmo(tmo3),
        .resp_valid(vld3), .resp_ready(rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Three races on the REPEATS=3 instance; index 0 is the first race.
    task automatic run3(input logic [2:0][3:0] a, input logic [2:0][3:0] b,
                        input logic [3:0] e_resp, input logic [3:0] e_tie,
                        input logic [3:0] e_tmo);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk1("r3_en_first", en3, 1'b1);
        for (int r = 0; r < 3; r++) begin
            fa3 = a[r];
            fb3 = b[r];
            if (r > 0) begin
                tick();
                chk1("r3_entry_no_sample", vld3, 1'b0);
            end
            tick();
            if (r < 2) begin
                chk1("r3_gap_low1", en3, 1'b0);
                chk1("r3_not_valid", vld3, 1'b0);
                fa3 = 4'b0000;
                fb3 = 4'b0000;
                tick();
                chk1("r3_gap_low2", en3, 1'b0);
                tick();
                chk1("r3_gap_rearmed", en3, 1'b1);
            end
        end
        chk1("r3_valid", vld3, 1'b1);
        chk4("r3_resp", resp3, e_resp);
        chk4("r3_tie", tie3, e_tie);
        chk4("r3_tmo", tmo3, e_tmo);
        fa3  = 4'b0000;
        fb3  = 4'b0000;
        rdy3 = 1'b1;
        tick();
        chk1("r3_handshake", vld3, 1'b0);
        rdy3 = 1'b0;
        tick();
    endtask

    initial begin
        rst1_n = 1'b0; start1 = 1'b0; rdy1 = 1'b0; fa1 = '0; fb1 = '0;
        rst3_n = 1'b0; start3 = 1'b0; rdy3 = 1'b0; fa3 = '0; fb3 = '0;
        tick();
        tick();
        chk1("rst_en", en1, 1'b0);
        chk1("rst_busy", busy1, 1'b0);
        chk1("rst_valid", vld1, 1'b0);
        chk4("rst_resp", resp1, 4'b0000);
        chk4("rst_tie", tie1, 4'b0000);
        chk4("rst_tmo", tmo1, 4'b0000);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        tick();

        // Single race, all channels decided on the first sample.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk1("t1_en", en1, 1'b1);
        chk1("t1_busy", busy1, 1'b1);
        fa1 = 4'b1010;
        fb1 = 4'b0101;
        tick();
        chk1("t1_valid", vld1, 1'b1);
        chk1("t1_en_low", en1, 1'b0);
        chk4("t1_resp", resp1, 4'b0101);
        chk4("t1_tie", tie1, 4'b0000);
        chk4("t1_tmo", tmo1, 4'b0000);
        rdy1 = 1'b1;
        fa1  = '0;
        fb1  = '0;
        tick();
        chk1("t1_idle_valid", vld1, 1'b0);
        chk1("t1_idle_busy", busy1, 1'b0);
        rdy1 = 1'b0;
        tick();

        // Tie on ch0, A on ch1, B on ch2, ch3 never finishes.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        fa1 = 4'b0011;
        fb1 = 4'b0101;
        tick();
        chk1("t2_not_valid_s1", vld1, 1'b0);
        chk4("t2_tie_early", tie1, 4'b0001);
        repeat (14) tick();
        chk1("t2_not_valid_s15", vld1, 1'b0);
        chk1("t2_en_s15", en1, 1'b1);
        tick();
        chk1("t2_valid_s16", vld1, 1'b1);
        chk4("t2_resp", resp1, 4'b0100);
        chk4("t2_tie", tie1, 4'b0001);
        chk4("t2_tmo", tmo1, 4'b1000);

        // Backpressure: hold DONE while start pulses.
        for (int i = 0; i < 10; i++) begin
            start1 = i[0];
            tick();
            chk1("bp_valid", vld1, 1'b1);
            chk1("bp_en", en1, 1'b0);
            chk4("bp_resp", resp1, 4'b0100);
            chk4("bp_tmo", tmo1, 4'b1000);
        end
        start1 = 1'b1;
        rdy1   = 1'b1;
        tick();
        chk1("bp_release_valid", vld1, 1'b0);
        chk1("bp_release_busy", busy1, 1'b0);
        start1 = 1'b0;
        rdy1   = 1'b0;
        fa1    = '0;
        fb1    = '0;
        tick();
        chk1("bp_no_restart", busy1, 1'b0);
        chk4("bp_tie_cleared", tie1, 4'b0000);
        chk4("bp_tmo_cleared", tmo1, 4'b0000);

        // Majority over three races: ch0 wins B, A, B.
        run3({4'b1110, 4'b1111, 4'b1110}, {4'b0001, 4'b0000, 4'b0001},
             4'b0001, 4'b0000, 4'b0000);

        // Reset during the second race discards the first race's vote.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        fa3 = 4'b1110;
        fb3 = 4'b0011;
        tick();
        chk4("rs_tie_before", tie3, 4'b0010);
        fa3 = '0;
        fb3 = '0;
        tick();
        tick();
        chk1("rs_en_race2", en3, 1'b1);
        rst3_n = 1'b0;
        #1;
        chk1("rs_en_async", en3, 1'b0);
        chk1("rs_busy", busy3, 1'b0);
        chk1("rs_valid", vld3, 1'b0);
        chk4("rs_resp", resp3, 4'b0000);
        chk4("rs_tie", tie3, 4'b0000);
        chk4("rs_tmo", tmo3, 4'b0000);
        tick();
        rst3_n = 1'b1;
        tick();
        // ch0 wins A, A, B: a stale vote would flip it to 1.
        run3({4'b1110, 4'b1111, 4'b1111}, {4'b0001, 4'b0000, 4'b0000},
             4'b0000, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/race_arbiter_array.md
# race_arbiter_array

Multi-channel, clocked successor to the single race arbiter for the arbiter-PUF datapath. It launches N_CH delay-line races at once and samples each channel's two finish lines every clock. For each channel it records which path finished first, any tie and any timeout. Races can be repeated an odd number of times with a per-channel majority vote, and the N_CH-bit response goes to the readout logic over a valid/ready handshake.

## Interface
- N_CH, 8: number of parallel race channels (≥1)
- TIMEOUT, 16: maximum clocks per race before undecided channels time out (≥1)
- REPEATS, 1: races per response; odd, ≥1
- REARM_CYC, 2: clocks with race_en low between repeated races (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a response; sampled only in IDLE
- fin_a  in  N_CH  path-A finish line per channel (finished1)
- fin_b  in  N_CH  path-B finish line per channel (finished2)
- race_en  out  1  launch/enable to the delay lines; high while racing
- busy  out  1  high in every state except IDLE
- resp  out  N_CH  majority response bit per channel
- tie  out  N_CH  sticky: channel saw fin_a and fin_b rise in the same cycle in any repeat
- tmo  out  N_CH  sticky: channel was undecided at timeout in any repeat
- resp_valid  out  1  resp/tie/tmo valid
- resp_ready  in  1  consumer accepts response

## Operation
- FSM states: IDLE, RACE, REARM, DONE.
- **IDLE**
  - start=1 → RACE.
  - Clear the repeat counter, cycle counter, all vote counters, tie and tmo.
- **RACE**
  - race_en=1. The cycle counter runs 0..TIMEOUT-1.
  - At each edge, each undecided channel resolves as follows:
    - fin_a=1, fin_b=0 → decided, vote 0
    - fin_a=0, fin_b=1 → decided, vote 1; vote counter +1
    - both 1 → decided, vote 0, tie bit set
    - both 0 → stays undecided
  - At the edge where the cycle counter equals TIMEOUT-1, every still-undecided channel sets its tmo bit and votes 0.
  - The race ends at the first edge where all channels are decided (after that edge's updates) or at the timeout edge, whichever comes first.
  - If more repeats remain → REARM; otherwise → DONE.
- **REARM**
  - race_en=0 for exactly REARM_CYC clocks.
  - Per-channel decided flags and the cycle counter are cleared.
  - Then → RACE.
- **DONE**
  - race_en=0, resp_valid=1.
  - resp[i] = (vote_cnt[i] > REPEATS/2).
  - resp, tie and tmo are held stable until the handshake.
  - resp_valid & resp_ready at an edge → IDLE.
- **Widths:** vote counters and repeat counter are $clog2(REPEATS+1) bits; the cycle counter is $clog2(TIMEOUT+1) bits. Vote counters never exceed REPEATS.
- **start handling:** start is ignored outside IDLE, including in the handshake cycle.
- **Input hold:** finish lines must hold high once risen within a race. A channel that is already decided ignores further input changes.
- **Reset:** all outputs are 0 on reset and the FSM goes to IDLE. Asserting rst_n low mid-race drops race_en immediately (asynchronous) and discards all partial votes.

## Timing
- start is sampled high at edge E0. race_en and busy go high after E0. fin is first sampled at E0+1.
- If all channels resolve at sampled edge E0+k (k≥1), the race ends at that edge.
  - REPEATS=1: resp_valid is high after E0+k.
  - General case, when every race resolves in k cycles: resp_valid rises after E0 + REPEATS·k + (REPEATS-1)·(REARM_CYC+1). The +1 is the RACE-entry cycle of each later repeat.
- A fully timed-out race lasts TIMEOUT sampled edges.
- The consumer may hold resp_ready high permanently. DONE then lasts exactly one cycle.
- resp, tie and tmo are registered and do not change while resp_valid=1.

## Structure
- Package puf_pkg:
  - arb_state_e enum (IDLE, RACE, REARM, DONE)
  - vote-encoding constants VOTE_A=0, VOTE_B=1
- One sub-module, race_channel, instantiated N_CH times. Each instance owns:
  - the decided flag
  - the tie and tmo sticky bits
  - the vote counter and majority compare
- race_channel takes from the top-level FSM: sample, timeout_edge and clear strobes.
- The top level holds the FSM, cycle/repeat/rearm counters and the all-decided reduction.

## Test plan
- N_CH=4, REPEATS=1: start, then fin_b=4'b0101 and fin_a=4'b1010 at the first sample → resp=4'b0101, tie=0, tmo=0, resp_valid one cycle after that sample.
- Tie and timeout, N_CH=4:
  - channel 0 gets fin_a=fin_b=1 in the same cycle → tie[0]=1, resp[0]=0
  - channel 3 never finishes → tmo[3]=1, resp[3]=0 after TIMEOUT=16 samples
- REPEATS=3, channel 0 wins B, A, B across the three races → resp[0]=1. race_en is low for exactly 2 cycles between races.
- Backpressure: resp_ready=0 for 10 cycles in DONE while start pulses → resp stable, no new race. resp_ready=1 → IDLE one edge later.
- Reset mid-operation: rst_n low during the second of 3 races → race_en drops immediately, all outputs 0. After release, a new start gives a clean response with no stale votes.
